alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// - Execute stage of the multi-cycle MIPS datapath: ALU control decode, 32-bit ALU, branch-condition AND, ALUOut register.
// - Decodes the controller's 2-bit ALUOp plus the instruction funct field into a 3-bit ALU control code.
// - Computes the result and zero flag, gates zero with PCWrCond for branches, and registers the result for the next state.
// PARAMETERS
// - WIDTH  32  datapath width in bits; all tests use 32
// PORTS
// - clk          in   1      clock; all state updates on rising edge
// - rst          in   1      synchronous reset, active-high
// - alu_op       in   2      ALUOp from controller
// - funct        in   6      inst[5:0]
// - src_a        in   WIDTH  ALU operand A (PC or register A)
// - src_b        in   WIDTH  ALU operand B (B, 4, sign-ext imm, shifted imm)
// - pc_wr_cond   in   1      controller branch-write condition
// - alu_ctrl     out  3      decoded ALU control code (combinational)
// - alu_result   out  WIDTH  combinational ALU result
// - alu_zero     out  1      1 when alu_result == 0 (combinational)
// - branch_take  out  1      pc_wr_cond & alu_zero (combinational)
// - aluout_q     out  WIDTH  registered ALU result (ALUOut)
// - ovf          out  1      only when ALU_OVF_EN is defined (see CONFIGURATION)
// BEHAVIOUR
// - ALU control decode, combinational:
//   - alu_op=00 -> 010 ADD (address / PC+4)
//   - alu_op=01 -> 110 SUB (beq compare)
//   - alu_op=11 -> 001 OR
//   - alu_op=10 -> decode funct:
//     - 100000 -> 010 ADD
//     - 100010 -> 110 SUB
//     - 100100 -> 000 AND
//     - 100101 -> 001 OR
//     - 101010 -> 111 SLT
//     - any other funct -> 010 ADD
// - ALU operation by alu_ctrl:
//   - 000 a&b
//   - 001 a|b
//   - 010 a+b, modulo 2^WIDTH; carry discarded
//   - 110 a-b, modulo 2^WIDTH
//   - 111 SLT: {0..0, signed(a)<signed(b)}, true signed compare, not subtraction sign
//   - 011/100/101 -> result 0
// - alu_zero = (alu_result == 0), evaluated on every op including AND/OR/SLT.
// - branch_take = pc_wr_cond & alu_zero; no registering, no latency.
// - aluout_q: loads alu_result on every rising clk edge; there is no enable.
//   - Latency 1 cycle from operands to aluout_q.
//   - Reset value 0.
// - rst=1 at an edge: aluout_q <= 0 (and ovf_q <= 0), overriding the load. Combinational outputs are unaffected by rst.
// - Reset asserted mid-operation discards the in-flight result. The first post-reset edge loads normally.
// - No X propagation: every alu_op/funct combination yields a defined alu_ctrl.
// CONFIGURATION
// - Macro ALU_OVF_EN.
// - Defined:
//   - Port ovf is added, driven from register ovf_q, reset 0, loaded each edge with the signed overflow of the current op.
//   - ADD overflow: operands have the same sign and the result sign differs.
//   - SUB overflow: operands have different signs and the result sign differs from a.
//   - All other ops: 0.
//   - Overflow never suppresses the result or the aluout_q load.
// - Undefined: no ovf port and no overflow logic; all other behaviour is identical.
// TESTING
// - alu_op=00, a=5, b=7 -> alu_ctrl=010, alu_result=12, zero=0; next edge aluout_q=12.
// - alu_op=01, a=b=0x1234, pc_wr_cond=1 -> result=0, zero=1, branch_take=1; same with pc_wr_cond=0 -> branch_take=0.
// - alu_op=10, funct=101010, a=0xFFFFFFFB(-5), b=3 -> result=1; swap operands -> result=0, zero=1.
// - alu_op=10, funct sweep 100100/100101 with a=0xF0F0F0F0, b=0x0FF00FF0 -> AND 0x00F000F0, OR 0xFFF0FFF0; funct=000000 -> ADD.
// - Load aluout_q=0xDEADBEEF, then assert rst for one edge with a=1, b=1 -> aluout_q=0; deassert -> next edge aluout_q=2.
// - ALU_OVF_EN defined: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1 after edge; SUB a=0x80000000, b=1 -> ovf=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle MIPS execute stage: ALU control, ALU, branch gate, ALUOut register
//
// Purpose:
//   Decodes ALUOp/funct into a 3-bit ALU control code and computes the ALU
//   result and zero flag. It gates zero with pc_wr_cond to form the branch
//   decision and registers the result into ALUOut for the next FSM state.
//
// Optional feature macro: ALU_OVF_EN (adds the registered signed-overflow port ovf)
//
// Ports:
//   clk          in   1      clock, rising-edge active
//   rst          in   1      synchronous reset, active-high
//   alu_op       in   2      ALUOp from controller
//   funct        in   6      instruction funct field inst[5:0]
//   src_a        in   WIDTH  operand A (PC or register A)
//   src_b        in   WIDTH  operand B (B, 4, sign-ext imm, shifted imm)
//   pc_wr_cond   in   1      controller branch-write condition
//   alu_ctrl     out  3      decoded ALU control code (combinational)
//   alu_result   out  WIDTH  ALU result (combinational)
//   alu_zero     out  1      alu_result == 0 (combinational)
//   branch_take  out  1      pc_wr_cond & alu_zero (combinational)
//   aluout_q     out  WIDTH  registered ALU result (ALUOut)
//   ovf          out  1      registered signed overflow (ALU_OVF_EN only)

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             pc_wr_cond,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic             branch_take,
`ifdef ALU_OVF_EN
  output logic [WIDTH-1:0] aluout_q,
  output logic             ovf
`else
  output logic [WIDTH-1:0] aluout_q
`endif
);

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;

  // ALU control decode; every alu_op/funct pair maps to a defined code.
  always_comb begin
    alu_ctrl = CTRL_ADD;
    unique case (alu_op)
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      2'b11: alu_ctrl = CTRL_OR;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctrl = CTRL_ADD;
          6'b100010: alu_ctrl = CTRL_SUB;
          6'b100100: alu_ctrl = CTRL_AND;
          6'b100101: alu_ctrl = CTRL_OR;
          6'b101010: alu_ctrl = CTRL_SLT;
          default:   alu_ctrl = CTRL_ADD;
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  // True signed compare: the sign of (a-b) is wrong when the subtraction overflows.
  assign slt_bit = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      CTRL_AND: alu_result = src_a & src_b;
      CTRL_OR:  alu_result = src_a | src_b;
      CTRL_ADD: alu_result = sum;
      CTRL_SUB: alu_result = diff;
      CTRL_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero    = (alu_result == '0);
  assign branch_take = pc_wr_cond & alu_zero;

  // ALUOut loads every edge; there is deliberately no enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluout_q <= '0;
    end else begin
      aluout_q <= alu_result;
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    case (alu_ctrl)
      CTRL_ADD: ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != src_a[WIDTH-1]);
      CTRL_SUB: ovf_d = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                        (diff[WIDTH-1] != src_a[WIDTH-1]);
      default:  ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        pc_wr_cond;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        branch_take;
  logic [31:0] aluout_q;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_assert;
  int n_fail;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .pc_wr_cond  (pc_wr_cond),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .branch_take (branch_take),
`ifdef ALU_OVF_EN
    .aluout_q    (aluout_q),
    .ovf         (ovf)
`else
    .aluout_q    (aluout_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    alu_op     = 2'b00;
    funct      = 6'b000000;
    src_a      = 32'd5;
    src_b      = 32'd7;
    pc_wr_cond = 1'b0;

    // Reset holds ALUOut at 0 even though the ALU is producing 12.
    tick;
    tick;
    check("reset_aluout", aluout_q, 32'd0);
`ifdef ALU_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    check("add_ctrl", {29'd0, alu_ctrl}, 32'h2);
    check("add_result_in_reset", alu_result, 32'd12);
    check("add_zero", {31'd0, alu_zero}, 32'd0);

    rst = 1'b0;
    tick;
    check("add_aluout", aluout_q, 32'd12);

    // beq compare
    alu_op     = 2'b01;
    src_a      = 32'h0000_1234;
    src_b      = 32'h0000_1234;
    pc_wr_cond = 1'b1;
    #1;
    check("sub_ctrl", {29'd0, alu_ctrl}, 32'h6);
    check("beq_result", alu_result, 32'd0);
    check("beq_zero", {31'd0, alu_zero}, 32'd1);
    check("beq_take", {31'd0, branch_take}, 32'd1);
    pc_wr_cond = 1'b0;
    #1;
    check("beq_no_cond", {31'd0, branch_take}, 32'd0);
    pc_wr_cond = 1'b1;
    src_b      = 32'h0000_1235;
    #1;
    check("bne_result", alu_result, 32'hFFFF_FFFF);
    check("bne_take", {31'd0, branch_take}, 32'd0);
    pc_wr_cond = 1'b0;

    // SLT
    alu_op = 2'b10;
    funct  = 6'b101010;
    src_a  = 32'hFFFF_FFFB;
    src_b  = 32'd3;
    #1;
    check("slt_ctrl", {29'd0, alu_ctrl}, 32'h7);
    check("slt_neg_lt_pos", alu_result, 32'd1);
    src_a = 32'd3;
    src_b = 32'hFFFF_FFFB;
    #1;
    check("slt_pos_lt_neg", alu_result, 32'd0);
    check("slt_zero", {31'd0, alu_zero}, 32'd1);
    // a-b overflows here, so the subtraction sign would give the wrong answer
    src_a = 32'h7FFF_FFFF;
    src_b = 32'h8000_0000;
    #1;
    check("slt_ovf_case", alu_result, 32'd0);

    // funct sweep
    src_a = 32'hF0F0_F0F0;
    src_b = 32'h0FF0_0FF0;
    funct = 6'b100100;
    #1;
    check("and_ctrl", {29'd0, alu_ctrl}, 32'h0);
    check("and_result", alu_result, 32'h00F0_00F0);
    funct = 6'b100101;
    #1;
    check("or_result", alu_result, 32'hFFF0_FFF0);
    funct = 6'b000000;
    #1;
    check("unk_funct_ctrl", {29'd0, alu_ctrl}, 32'h2);
    check("unk_funct_add", alu_result, 32'h00E1_00E0);
    funct = 6'b100000;
    #1;
    check("funct_add", alu_result, 32'h00E1_00E0);
    funct = 6'b100010;
    src_a = 32'd5;
    src_b = 32'd7;
    #1;
    check("funct_sub", alu_result, 32'hFFFF_FFFE);
    alu_op = 2'b11;
    src_a  = 32'h0000_00F0;
    src_b  = 32'h0000_000F;
    #1;
    check("op11_ctrl", {29'd0, alu_ctrl}, 32'h1);
    check("op11_or", alu_result, 32'h0000_00FF);
    // AND that clears every bit still raises zero
    alu_op = 2'b10;
    funct  = 6'b100100;
    #1;
    check("and_zero", {31'd0, alu_zero}, 32'd1);

    // carry out of the top bit is discarded
    alu_op = 2'b00;
    src_a  = 32'hFFFF_FFFF;
    src_b  = 32'd1;
    #1;
    check("add_wrap", alu_result, 32'd0);
    check("add_wrap_zero", {31'd0, alu_zero}, 32'd1);

    // back-to-back loads, one cycle latency
    src_a = 32'd100;
    src_b = 32'd23;
    tick;
    check("pipe_1", aluout_q, 32'd123);
    src_a = 32'd1000;
    src_b = 32'd1;
    tick;
    check("pipe_2", aluout_q, 32'd1001);

    // reset discards a loaded value
    src_a = 32'hDEAD_BEEF;
    src_b = 32'd0;
    tick;
    check("load_deadbeef", aluout_q, 32'hDEAD_BEEF);
    rst   = 1'b1;
    src_a = 32'd1;
    src_b = 32'd1;
    tick;
    check("mid_reset", aluout_q, 32'd0);
    check("mid_reset_comb", alu_result, 32'd2);
    rst = 1'b0;
    tick;
    check("post_reset_load", aluout_q, 32'd2);

`ifdef ALU_OVF_EN
    src_a = 32'h7FFF_FFFF;
    src_b = 32'd1;
    tick;
    check("ovf_add_result", aluout_q, 32'h8000_0000);
    check("ovf_add", {31'd0, ovf}, 32'd1);
    alu_op = 2'b01;
    src_a  = 32'h8000_0000;
    src_b  = 32'd1;
    tick;
    check("ovf_sub_result", aluout_q, 32'h7FFF_FFFF);
    check("ovf_sub", {31'd0, ovf}, 32'd1);
    src_a = 32'd5;
    src_b = 32'd7;
    tick;
    check("ovf_sub_none", {31'd0, ovf}, 32'd0);
    alu_op = 2'b11;
    src_a  = 32'h7FFF_FFFF;
    src_b  = 32'h0000_0001;
    tick;
    check("ovf_or_none", {31'd0, ovf}, 32'd0);
    alu_op = 2'b00;
    src_a  = 32'h8000_0000;
    src_b  = 32'h8000_0000;
    tick;
    check("ovf_add_neg", {31'd0, ovf}, 32'd1);
    rst = 1'b1;
    tick;
    check("ovf_reset", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
